// File: rtl/param_stack_fifo_if.sv
// Request/status bundle of param_stack_fifo: the producer/consumer side drives the
// master modport, the buffer sits on the slave modport.
interface param_stack_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  error_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output read, write, data_in, error_clr,
        input  data_out, count, full, empty, overflow, underflow
    );

    modport slave (
        input  read, write, data_in, error_clr,
        output data_out, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/param_stack_fifo.sv
// RAM-backed buffer returning words in FIFO (MODE=0) or LIFO (MODE=1) order, with
// count/full/empty status, sticky overflow/underflow and optional edge-qualified requests.
module param_stack_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned MODE        = 0,
    parameter int unsigned EDGE_DETECT = 1
) (
    input  logic                clk,
    input  logic                reset,
    param_stack_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wp_q, wp_d;
    logic [AW-1:0]         rp_q, rp_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  read_q, write_q;

    logic                  rd_req, wr_req;
    logic                  full, empty;
    logic                  both, wr_ok, rd_ok;
    logic [AW-1:0]         top_idx;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        rd_req      = (EDGE_DETECT != 0) ? (bus.read & ~read_q) : bus.read;
        wr_req      = (EDGE_DETECT != 0) ? (bus.write & ~write_q) : bus.write;
        // A read+write pair on a non-empty buffer is always taken, even when full.
        both        = rd_req & wr_req & ~empty;
        wr_ok       = wr_req & (~full | both);
        rd_ok       = rd_req & ~empty;
        top_idx     = count_q[AW-1:0] - AW'(1);

        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        mem_we      = 1'b0;
        mem_waddr   = wp_q;
        mem_wdata   = bus.data_in;

        if (MODE == 0) begin
            if (wr_ok) begin
                mem_we    = 1'b1;
                mem_waddr = wp_q;
                wp_d      = wp_q + AW'(1);
            end
            if (rd_ok) begin
                data_out_d = mem[rp_q];
                rp_d       = rp_q + AW'(1);
            end
        end else begin
            // Stack pointer is the count itself; a simultaneous pop+push replaces the top.
            if (wr_ok) begin
                mem_we    = 1'b1;
                mem_waddr = rd_ok ? top_idx : count_q[AW-1:0];
            end
            if (rd_ok) begin
                data_out_d = mem[top_idx];
            end
        end

        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end

        overflow_d  = (overflow_q & ~bus.error_clr) | (wr_req & ~wr_ok);
        underflow_d = (underflow_q & ~bus.error_clr) | (rd_req & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            read_q      <= bus.read;
            write_q     <= bus.write;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
